// File: rtl/procesador_acumulador_pkg.sv
// Shared constants for the five-bit accumulator datapath: widths and ALU opcodes.
package procesador_acumulador_pkg;

   localparam int DATA_W = 5;
   localparam int OP_W   = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'b000;
   localparam logic [OP_W-1:0] OP_OR   = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
   localparam logic [OP_W-1:0] OP_ANDN = 3'b100;
   localparam logic [OP_W-1:0] OP_ORN  = 3'b101;
   localparam logic [OP_W-1:0] OP_SLT  = 3'b110;
   localparam logic [OP_W-1:0] OP_ZERO = 3'b111;

   // Zero detect shared by the flag logic.
   function automatic logic is_zero(input logic [DATA_W-1:0] value);
      return ~|value;
   endfunction

endpackage

// File: rtl/alu5.sv
// Five-bit ALU with 3-bit opcode, carry/borrow flag and zero flag.
module alu5
   import procesador_acumulador_pkg::*;
(
   input  logic [OP_W-1:0]   f,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);

   logic [DATA_W:0]   sum_s;
   logic [DATA_W:0]   diff_s;
   logic [DATA_W-1:0] result_s;
   logic              carry_s;

   // Operation select; subtraction is X + ~Y + 1 so its carry means "no borrow".
   always_comb begin
      sum_s    = {1'b0, x} + {1'b0, y};
      diff_s   = {1'b0, x} + {1'b0, ~y} + 6'd1;
      result_s = 5'b00000;
      carry_s  = 1'b0;
      case (f)
         OP_AND:  result_s = x & y;
         OP_OR:   result_s = x | y;
         OP_ADD: begin
            result_s = sum_s[DATA_W-1:0];
            carry_s  = sum_s[DATA_W];
         end
         OP_SUB: begin
            result_s = diff_s[DATA_W-1:0];
            carry_s  = diff_s[DATA_W];
         end
         OP_ANDN: result_s = x & ~y;
         OP_ORN:  result_s = x | ~y;
         OP_SLT:  result_s = {4'b0000, (x < y)};
         OP_ZERO: result_s = 5'b00000;
         default: begin
            result_s = 5'b00000;
            carry_s  = 1'b0;
         end
      endcase
   end

   assign result = result_s;
   assign carry  = carry_s;
   assign zero   = is_zero(result_s);

endmodule

// File: rtl/bus_driver.sv
// Tri-state bus driver: puts B on the data bus when enabled. A second, always
// driven copy of the bus (zero when disabled) feeds the ALU so it never sees Z.
module bus_driver
   import procesador_acumulador_pkg::*;
(
   input  logic              en,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] db,
   output logic [DATA_W-1:0] bus
);

   assign db  = en ? b : 5'bzzzzz;
   assign bus = en ? b : 5'b00000;

endmodule

// File: rtl/reg5_en.sv
// Five-bit register with asynchronous active-low clear and load enable.
module reg5_en
   import procesador_acumulador_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] q_r;

   // Capture d on enabled edges; clear immediately when reset is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= 5'b00000;
      end else if (load) begin
         q_r <= d;
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/procesador_acumulador.sv
// Accumulator datapath top: bus driver -> ALU -> accumulator (fed back as X)
// and a separate output register. Wiring only.
module procesador_acumulador
   import procesador_acumulador_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [OP_W-1:0]   F,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic              enableDB,
   input  logic              enableR,
   input  logic              enableFF,
   output logic [DATA_W-1:0] outDB,
   output logic [DATA_W-1:0] outR,
   output logic [DATA_W-1:0] outALU,
   output logic [DATA_W-1:0] outFF,
   output logic              C,
   output logic              ZE
);

   logic [DATA_W-1:0] bus_s;
   logic [DATA_W-1:0] alu_s;
   logic [DATA_W-1:0] acc_s;
   logic              unused_a_s;

   // A is kept only for port compatibility with earlier revisions.
   assign unused_a_s = ^A;

   bus_driver u_bus (
      .en  (enableDB),
      .b   (B),
      .db  (outDB),
      .bus (bus_s)
   );

   alu5 u_alu (
      .f      (F),
      .x      (acc_s),
      .y      (bus_s),
      .result (alu_s),
      .carry  (C),
      .zero   (ZE)
   );

   reg5_en u_acc (
      .clk   (clk),
      .rst_n (reset),
      .load  (enableR),
      .d     (alu_s),
      .q     (acc_s)
   );

   reg5_en u_out (
      .clk   (clk),
      .rst_n (reset),
      .load  (enableFF),
      .d     (alu_s),
      .q     (outFF)
   );

   assign outR   = acc_s;
   assign outALU = alu_s;

endmodule

// File: tb/tb_procesador_acumulador.sv
// Self-checking bench for procesador_acumulador: reference model of the ALU,
// scoreboard of expected register contents popped after each clock edge.
module tb_procesador_acumulador;

   logic       clk;
   logic       reset;
   logic [2:0] F;
   logic [4:0] A;
   logic [4:0] B;
   logic       enableDB;
   logic       enableR;
   logic       enableFF;
   wire  [4:0] outDB;
   logic [4:0] outR;
   logic [4:0] outALU;
   logic [4:0] outFF;
   logic       C;
   logic       ZE;

   typedef struct {
      logic [4:0] r;
      logic [4:0] ff;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   model_r  = 0;
   int   model_ff = 0;

   procesador_acumulador dut (
      .clk      (clk),
      .reset    (reset),
      .F        (F),
      .A        (A),
      .B        (B),
      .enableDB (enableDB),
      .enableR  (enableR),
      .enableFF (enableFF),
      .outDB    (outDB),
      .outR     (outR),
      .outALU   (outALU),
      .outFF    (outFF),
      .C        (C),
      .ZE       (ZE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU written with plain integer arithmetic.
   function automatic void ref_alu(input int f, input int x, input int y,
                                   output int res, output int c);
      c = 0;
      case (f)
         0: res = x & y;
         1: res = x | y;
         2: begin res = (x + y) % 32; c = (x + y > 31) ? 1 : 0; end
         3: begin res = (x - y + 32) % 32; c = (x >= y) ? 1 : 0; end
         4: res = x & (31 - y);
         5: res = x | (31 - y);
         6: res = (x < y) ? 1 : 0;
         default: res = 0;
      endcase
   endfunction

   function automatic int bus_val();
      return enableDB ? int'(B) : 0;
   endfunction

   // Predict both registers, push, clock once, pop and compare.
   task automatic clock_edge();
      int   alu;
      int   c;
      exp_t e;
      exp_t got;
      ref_alu(int'(F), model_r, bus_val(), alu, c);
      e.r  = enableR  ? alu[4:0] : model_r[4:0];
      e.ff = enableFF ? alu[4:0] : model_ff[4:0];
      sb_q.push_back(e);
      @(posedge clk);
      model_r  = int'(e.r);
      model_ff = int'(e.ff);
      #1;
      got = sb_q.pop_front();
      checks++;
      if (outR !== got.r) begin
         failures++;
         $display("FAIL sb_outR: got %0d expected %0d", outR, got.r);
      end
      checks++;
      if (outFF !== got.ff) begin
         failures++;
         $display("FAIL sb_outFF: got %0d expected %0d", outFF, got.ff);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; F = 3'b000; A = 5'b10101; B = 5'b01110;
      enableDB = 1'b1; enableR = 1'b1; enableFF = 1'b1;
      #2;
      checks++;
      if (outR !== 5'd0 || outFF !== 5'd0) begin
         failures++;
         $display("FAIL reset_regs: got outR=%0d outFF=%0d expected 0 0", outR, outFF);
      end
      checks++;
      if (ZE !== 1'b1 || C !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: got ZE=%0b C=%0b expected 1 0", ZE, C);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (outR !== 5'd0 || outFF !== 5'd0) begin
         failures++;
         $display("FAIL reset_hold: got outR=%0d outFF=%0d expected 0 0", outR, outFF);
      end
   endtask

   task automatic test_bus_gating();
      F = 3'b001; B = 5'b00011; enableDB = 1'b0;
      #1;
      // A 2-state simulator resolves an undriven bus to 0 rather than Z.
      checks++;
      if (outDB !== 5'bzzzzz && outDB !== 5'b00000) begin
         failures++;
         $display("FAIL bus_float: got outDB=%b expected zzzzz", outDB);
      end
      checks++;
      if (outALU !== 5'd0 || ZE !== 1'b1) begin
         failures++;
         $display("FAIL bus_gated_alu: got outALU=%0d ZE=%0b expected 0 1", outALU, ZE);
      end
      enableDB = 1'b1;
      #1;
      checks++;
      if (outDB !== 5'b00011 || outALU !== 5'd3) begin
         failures++;
         $display("FAIL bus_drive: got outDB=%b outALU=%0d expected 00011 3", outDB, outALU);
      end
   endtask

   task automatic test_accumulate();
      reset = 1'b1;
      F = 3'b010; B = 5'd3; enableDB = 1'b1; enableR = 1'b1; enableFF = 1'b1;
      for (int i = 0; i < 4; i++) clock_edge();
      checks++;
      if (outR !== 5'd12) begin
         failures++;
         $display("FAIL accumulate_by3: got %0d expected 12", outR);
      end
      B = 5'd1;
      for (int i = 0; i < 3; i++) clock_edge();
      checks++;
      if (outR !== 5'd15 || outFF !== 5'd15) begin
         failures++;
         $display("FAIL accumulate_by1: got %0d/%0d expected 15/15", outR, outFF);
      end
   endtask

   task automatic reload(input logic [4:0] value);
      reset = 1'b0; #1;
      model_r = 0; model_ff = 0;
      reset = 1'b1;
      F = 3'b010; B = value; enableDB = 1'b1; enableR = 1'b1; enableFF = 1'b1;
      clock_edge();
   endtask

   task automatic test_subtract();
      int   exp_res [3] = '{3, 0, 31};
      logic exp_c   [3] = '{1'b1, 1'b1, 1'b0};
      logic exp_z   [3] = '{1'b0, 1'b1, 1'b0};
      logic [4:0] bs [3] = '{5'd1, 5'd4, 5'd5};
      reload(5'd4);
      enableR = 1'b0; enableFF = 1'b0; F = 3'b011;
      for (int i = 0; i < 3; i++) begin
         B = bs[i];
         #1;
         checks++;
         if (outALU !== exp_res[i][4:0] || C !== exp_c[i] || ZE !== exp_z[i]) begin
            failures++;
            $display("FAIL subtract_%0d: got outALU=%0d C=%0b ZE=%0b expected %0d %0b %0b",
                     i, outALU, C, ZE, exp_res[i], exp_c[i], exp_z[i]);
         end
      end
   endtask

   task automatic test_enables();
      reload(5'd4);
      F = 3'b010; B = 5'd2;
      enableR = 1'b0; enableFF = 1'b1;
      clock_edge();
      checks++;
      if (outR !== 5'd4 || outFF !== 5'd6) begin
         failures++;
         $display("FAIL enable_ff_only: got %0d/%0d expected 4/6", outR, outFF);
      end
      enableR = 1'b1; enableFF = 1'b0;
      clock_edge();
      clock_edge();
      checks++;
      if (outR !== 5'd8 || outFF !== 5'd6) begin
         failures++;
         $display("FAIL enable_r_only: got %0d/%0d expected 8/6", outR, outFF);
      end
   endtask

   task automatic test_overflow_reset();
      reload(5'd31);
      F = 3'b010; B = 5'd1;
      #1;
      checks++;
      if (outALU !== 5'd0 || C !== 1'b1 || ZE !== 1'b1) begin
         failures++;
         $display("FAIL overflow: got outALU=%0d C=%0b ZE=%0b expected 0 1 1", outALU, C, ZE);
      end
      F = 3'b011;
      reload(5'd0);
      F = 3'b011; B = 5'd1; enableR = 1'b0; enableFF = 1'b0;
      #1;
      checks++;
      if (outALU !== 5'd31 || C !== 1'b0) begin
         failures++;
         $display("FAIL underflow: got outALU=%0d C=%0b expected 31 0", outALU, C);
      end
      reload(5'd5);
      #2;
      reset = 1'b0;
      #1;
      model_r = 0; model_ff = 0;
      checks++;
      if (outR !== 5'd0 || outFF !== 5'd0 || outALU !== 5'd5) begin
         failures++;
         $display("FAIL async_reset: got outR=%0d outFF=%0d outALU=%0d expected 0 0 5",
                  outR, outFF, outALU);
      end
      reset = 1'b1;
   endtask

   task automatic test_back_to_back();
      int res;
      int c;
      for (int i = 0; i < 40; i++) begin
         F        = 3'($urandom_range(7, 0));
         B        = 5'($urandom_range(31, 0));
         enableDB = 1'($urandom_range(1, 0));
         enableR  = 1'($urandom_range(1, 0));
         enableFF = 1'($urandom_range(1, 0));
         #1;
         ref_alu(int'(F), model_r, bus_val(), res, c);
         checks++;
         if (outALU !== res[4:0] || C !== c[0] || ZE !== (res == 0)) begin
            failures++;
            $display("FAIL b2b_alu F=%0d X=%0d Y=%0d: got %0d C=%0b ZE=%0b expected %0d C=%0d",
                     F, model_r, bus_val(), outALU, C, ZE, res, c);
         end
         clock_edge();
      end
   endtask

   initial begin
      test_reset();
      test_bus_gating();
      test_accumulate();
      test_subtract();
      test_enables();
      test_overflow_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
